// File: rtl/switch_port_rx.sv
// switch_port_rx: receive side of one switch output port.
// Reserves FIFO space for a whole packet before granting it with a one-cycle
// proceed pulse, captures the burst, and replays it as a framed valid/ready
// byte stream. Optional macro SWITCH_PORT_RX_BYTE_COUNT_EN adds a running
// byte_count output.
module switch_port_rx #(
    parameter int FIFO_DEPTH = 64,
    parameter int DATA_W     = 8,
    parameter int LEN_W      = 5,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LEN_W-1:0]  newdata_len,
    input  logic [DATA_W-1:0] data_out,
    output logic              proceed,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_last,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  pkt_count
`ifdef SWITCH_PORT_RX_BYTE_COUNT_EN
    ,
    output logic [CNT_W-1:0]  byte_count
`endif
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CMP_W = (LEN_W > AW + 1) ? LEN_W : AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RECV, S_GAP} state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              proceed_q;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q, count_d;
    logic [AW:0]       free;
    logic [CNT_W-1:0]  pkt_count_q;
    logic [DATA_W:0]   mem [FIFO_DEPTH];
    logic              push, push_last, pop;

    // Space check uses the occupancy before this cycle's pop, so a grant
    // never relies on a byte leaving in the same cycle.
    assign free     = (AW + 1)'(FIFO_DEPTH) - count_q;
    assign rx_valid = (count_q != '0);
    assign pop      = rx_valid && rx_ready;
    assign rx_data  = rx_valid ? mem[rd_ptr_q][DATA_W-1:0] : '0;
    assign rx_last  = rx_valid & mem[rd_ptr_q][DATA_W];
    assign proceed  = proceed_q;
    assign busy     = (state_q != S_IDLE);
    assign pkt_count = pkt_count_q;

    // Grant/receive sequencing and FIFO write request.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        rem_d     = rem_q;
        push      = 1'b0;
        push_last = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (newdata_len != '0 && CMP_W'(free) >= CMP_W'(newdata_len)) begin
                    len_d   = newdata_len;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                rem_d   = len_q;
                state_d = S_RECV;
            end
            S_RECV: begin
                push      = 1'b1;
                push_last = (rem_q == LEN_W'(1));
                rem_d     = rem_q - LEN_W'(1);
                if (push_last) state_d = S_GAP;
            end
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state, pointers and packet counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            rem_q       <= '0;
            proceed_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            rem_q     <= rem_d;
            proceed_q <= (state_d == S_GRANT);
            count_q   <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && push_last) pkt_count_q <= pkt_count_q + CNT_W'(1);
        end
    end

    // Storage holds {last, byte}; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {push_last, data_out};
    end

`ifdef SWITCH_PORT_RX_BYTE_COUNT_EN
    logic [CNT_W-1:0] byte_count_q;
    assign byte_count = byte_count_q;

    // Running count of every byte captured from the switch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     byte_count_q <= '0;
        else if (push) byte_count_q <= byte_count_q + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_switch_port_rx.sv
// Bench for switch_port_rx: the bench plays the switch port, keeps a queue of
// every byte it sent (with its expected last flag) and checks each popped
// byte against it, plus grant timing and counters.
`timescale 1ns/1ps
module tb_switch_port_rx;
    localparam int DEPTH = 64;
    localparam int DW    = 8;
    localparam int LW    = 5;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [LW-1:0] newdata_len = '0;
    logic [DW-1:0] data_out = '0;
    logic          proceed;
    logic [DW-1:0] rx_data;
    logic          rx_last;
    logic          rx_valid;
    logic          rx_ready = 1'b0;
    logic          busy;
    logic [CW-1:0] pkt_count;
`ifdef SWITCH_PORT_RX_BYTE_COUNT_EN
    logic [CW-1:0] byte_count;
`endif

    int checks = 0;
    int errors = 0;
    int pkts = 0;
    int bytes_m = 0;
    int popped = 0;
    int cyc = 0;
    int gcyc = 0;
    bit rnd_ready = 1'b0;
    logic [DW:0] expq [$];

    switch_port_rx #(.FIFO_DEPTH(DEPTH), .DATA_W(DW), .LEN_W(LW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .newdata_len(newdata_len), .data_out(data_out),
        .proceed(proceed), .rx_data(rx_data), .rx_last(rx_last), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .busy(busy), .pkt_count(pkt_count)
`ifdef SWITCH_PORT_RX_BYTE_COUNT_EN
        , .byte_count(byte_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1);
    end

    // One clock: check any pop at the falling edge, then move past the rising edge.
    task automatic step();
        logic [DW:0] e;
        @(negedge clk);
        if (!reset && rx_valid === 1'b1 && rx_ready === 1'b1) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL pop_extra got data=%h last=%0b required no data", rx_data, rx_last);
            end else begin
                e = expq.pop_front();
                popped++;
                if ({rx_last, rx_data} !== e) begin
                    errors++;
                    $display("FAIL pop_data got last=%0b data=%h required last=%0b data=%h",
                             rx_last, rx_data, e[DW], e[DW-1:0]);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rnd_ready) rx_ready = 1'($urandom_range(0, 1));
    endtask

    // Act as the switch: offer len, wait for the grant, then stream len bytes.
    task automatic send_pkt(input int len, input int next_len, input logic [DW-1:0] base,
                            input bit fixed, output int lat);
        logic [DW-1:0] d;
        newdata_len = LW'(len);
        lat = 0;
        while (proceed !== 1'b1 && lat < 400) begin
            step();
            lat++;
        end
        checks++;
        if (proceed !== 1'b1) begin
            errors++;
            $display("FAIL grant_timeout len=%0d got proceed=%0b required 1", len, proceed);
            newdata_len = '0;
            return;
        end
        gcyc = cyc;
        newdata_len = LW'(next_len);
        step();
        checks++;
        if (proceed !== 1'b0) begin
            errors++;
            $display("FAIL proceed_width got %0b required 0", proceed);
        end
        for (int i = 0; i < len; i++) begin
            d = fixed ? base + DW'(i) : DW'($urandom);
            data_out = d;
            expq.push_back({1'(i == len - 1), d});
            bytes_m++;
            step();
        end
        data_out = '0;
        pkts++;
        checks++;
        if (pkt_count !== CW'(pkts)) begin
            errors++;
            $display("FAIL pkt_count got %0d required %0d", pkt_count, CW'(pkts));
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        rx_ready = 1'b1;
        while (expq.size() != 0 && n < 500) begin
            step();
            n++;
        end
        checks++;
        if (expq.size() != 0 || rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain got left=%0d rx_valid=%0b required 0 0", name, expq.size(), rx_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        newdata_len = '0;
        data_out = '0;
        rx_ready = 1'b0;
        repeat (3) step();
        checks++; if (proceed !== 1'b0) begin errors++; $display("FAIL rst_proceed got %0b required 0", proceed); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b required 0", busy); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b required 0", rx_valid); end
        checks++; if (rx_last !== 1'b0) begin errors++; $display("FAIL rst_last got %0b required 0", rx_last); end
        checks++; if (rx_data !== '0) begin errors++; $display("FAIL rst_data got %h required 0", rx_data); end
        checks++; if (pkt_count !== '0) begin errors++; $display("FAIL rst_pkt_count got %0d required 0", pkt_count); end
`ifdef SWITCH_PORT_RX_BYTE_COUNT_EN
        checks++; if (byte_count !== '0) begin errors++; $display("FAIL rst_byte_count got %0d required 0", byte_count); end
`endif
        reset = 1'b0;
        repeat (2) step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %0b required 0", busy); end
    endtask

    task automatic test_basic();
        int lat, p0;
        rx_ready = 1'b1;
        p0 = popped;
        send_pkt(3, 0, 8'hA1, 1'b1, lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL basic_latency got %0d required 1", lat); end
        drain("basic");
        checks++; if (popped - p0 != 3) begin errors++; $display("FAIL basic_popped got %0d required 3", popped - p0); end
    endtask

    task automatic test_backpressure();
        int lat, nhigh;
        rx_ready = 1'b0;
        repeat (2) step();
        send_pkt(31, 0, 8'h00, 1'b0, lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL bp_lat1 got %0d required 1", lat); end
        send_pkt(31, 0, 8'h00, 1'b0, lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL bp_lat2 got %0d required 2", lat); end
        newdata_len = LW'(5);
        nhigh = 0;
        repeat (10) begin
            step();
            if (proceed === 1'b1) nhigh++;
        end
        checks++; if (nhigh != 0) begin errors++; $display("FAIL bp_no_grant got %0d pulses required 0", nhigh); end
        rx_ready = 1'b1;
        repeat (3) step();
        rx_ready = 1'b0;
        send_pkt(5, 0, 8'h00, 1'b0, lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL bp_after_pop got %0d required 1", lat); end
    endtask

    task automatic test_full();
        int lat, nhigh;
        checks++; if (expq.size() != DEPTH) begin errors++; $display("FAIL full_setup got %0d required %0d", expq.size(), DEPTH); end
        newdata_len = LW'(1);
        nhigh = 0;
        repeat (6) begin
            step();
            if (proceed === 1'b1) nhigh++;
        end
        checks++; if (nhigh != 0) begin errors++; $display("FAIL full_no_grant got %0d pulses required 0", nhigh); end
        rx_ready = 1'b1;
        send_pkt(1, 0, 8'hC3, 1'b1, lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL full_grant_lat got %0d required 2", lat); end
        drain("full");
    endtask

    task automatic test_back_to_back();
        int lat, prev;
        rx_ready = 1'b1;
        repeat (2) step();
        send_pkt(1, 1, 8'h5A, 1'b1, lat);
        for (int k = 1; k < 4; k++) begin
            prev = gcyc;
            send_pkt(1, (k == 3) ? 0 : 1, 8'h5A, 1'b1, lat);
            checks++;
            if (gcyc - prev != 4) begin
                errors++;
                $display("FAIL b2b_spacing got %0d required 4", gcyc - prev);
            end
        end
        drain("b2b");
    endtask

    task automatic test_reset_mid();
        int n, lat;
        rx_ready = 1'b0;
        repeat (2) step();
        newdata_len = LW'(10);
        n = 0;
        while (proceed !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        checks++; if (proceed !== 1'b1) begin errors++; $display("FAIL mid_grant got %0b required 1", proceed); end
        newdata_len = '0;
        step();
        repeat (2) begin
            data_out = DW'($urandom);
            step();
        end
        checks++; if (rx_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL mid_pre got valid=%0b busy=%0b required 1 1", rx_valid, busy); end
        #2 reset = 1'b1;
        #1;
        checks++; if (proceed !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_ctrl got proceed=%0b busy=%0b required 0 0", proceed, busy); end
        checks++; if (rx_valid !== 1'b0 || rx_last !== 1'b0 || rx_data !== '0) begin errors++; $display("FAIL mid_rx got valid=%0b last=%0b data=%h required 0 0 00", rx_valid, rx_last, rx_data); end
        checks++; if (pkt_count !== '0) begin errors++; $display("FAIL mid_pkt_count got %0d required 0", pkt_count); end
        expq.delete();
        pkts = 0;
        bytes_m = 0;
        data_out = '0;
        repeat (2) step();
        reset = 1'b0;
        rx_ready = 1'b1;
        step();
        send_pkt(4, 0, 8'h00, 1'b0, lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL mid_restart_lat got %0d required 1", lat); end
        drain("mid");
    endtask

    task automatic test_wrap();
        int lat;
        rnd_ready = 1'b1;
        for (int k = 0; k < 16; k++) send_pkt($urandom_range(1, 31), 0, 8'h00, 1'b0, lat);
        rnd_ready = 1'b0;
        drain("wrap");
        checks++; if (pkt_count !== CW'(pkts)) begin errors++; $display("FAIL wrap_pkt_count got %0d required %0d", pkt_count, CW'(pkts)); end
`ifdef SWITCH_PORT_RX_BYTE_COUNT_EN
        checks++; if (byte_count !== CW'(bytes_m)) begin errors++; $display("FAIL wrap_byte_count got %0d required %0d", byte_count, CW'(bytes_m)); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_full();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
